// File: rtl/vec_mem_sequencer.sv
// Serializes one R-lane vector load/store over the single N-bit data-memory port,
// stalling the pipeline for the duration and assembling load lanes into rdata_vec.
module vec_mem_sequencer #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 6,
  parameter int unsigned A = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           is_write,
  input  logic [A-1:0]   base_addr,
  input  logic [R*N-1:0] wdata_vec,
  input  logic [N-1:0]   mem_rdata,
  output logic [A-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  output logic           stall,
  output logic [R*N-1:0] rdata_vec,
  output logic           done
);

  localparam int unsigned IdxW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(R - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StStore, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [A-1:0]    base_q, base_d;
  logic [R*N-1:0]  wdata_q, wdata_d;
  logic [R*N-1:0]  rdata_q, rdata_d;
  logic [A-1:0]    lane_addr;
  logic [N-1:0]    lane_wdata;

  // Address wraps silently modulo 2^A.
  assign lane_addr = base_q + A'(idx_q);
  assign rdata_vec = rdata_q;

  always_comb begin
    lane_wdata = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (idx_q == IdxW'(i)) lane_wdata = wdata_q[i*N +: N];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = start;
        if (start) begin
          base_d  = base_addr;
          wdata_d = wdata_vec;
          idx_d   = '0;
          state_d = is_write ? StStore : StLoad;
        end
      end
      StLoad: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = lane_addr;
        // Read data trails the address by one cycle, so this cycle returns lane idx-1.
        for (int unsigned i = 1; i < R; i++) begin
          if (idx_q == IdxW'(i)) rdata_d[(i-1)*N +: N] = mem_rdata;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        stall                  = 1'b1;
        rdata_d[(R-1)*N +: N]  = mem_rdata;
        state_d                = StDone;
      end
      StStore: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lane_addr;
        mem_wdata = lane_wdata;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench: transaction-level expectation queue plus directed literal checks.
module tb_vec_mem_sequencer;

  localparam int unsigned N = 8;
  localparam int unsigned R = 6;
  localparam int unsigned A = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           is_write = 1'b0;
  logic [A-1:0]   base_addr = '0;
  logic [R*N-1:0] wdata_vec = '0;
  logic [N-1:0]   mem_rdata = '0;
  logic [A-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic           stall;
  logic [R*N-1:0] rdata_vec;
  logic           done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_mem_sequencer #(.N(N), .R(R), .A(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_write  (is_write),
    .base_addr (base_addr),
    .wdata_vec (wdata_vec),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .stall     (stall),
    .rdata_vec (rdata_vec),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus memory written by the DUT; ref memory written only by the model.
  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_val(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) bus_mem[mem_addr] = mem_wdata;
    mem_rdata <= mem_re ? bus_rd(mem_addr) : 8'($urandom);
  end

  typedef struct packed {
    logic        stall;
    logic        re;
    logic        we;
    logic        dn;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t           q[$];
  logic [R*N-1:0] exp_rdata = '0;
  logic [R*N-1:0] pend_vec = '0;
  logic           pend_load = 1'b0;

  // Whole transfer laid out as one expected output record per cycle after start.
  function automatic void build(input logic wr, input logic [31:0] b, input logic [R*N-1:0] wv);
    exp_t e;
    for (int i = 0; i < R; i++) begin
      e = '0;
      e.stall = 1'b1;
      e.addr = b + 32'(i);
      if (wr) begin
        e.we = 1'b1;
        e.wdata = wv[i*8 +: 8];
      end else begin
        e.re = 1'b1;
        pend_vec[i*8 +: 8] = ref_rd(b + 32'(i));
      end
      q.push_back(e);
    end
    if (!wr) begin
      e = '0;
      e.stall = 1'b1;
      q.push_back(e);
    end
    e = '0;
    e.dn = 1'b1;
    q.push_back(e);
    pend_load = !wr;
  endfunction

  // Observation logs for the directed tests.
  int          cyc_rel = 0;
  int          stall_cnt = 0, re_cnt = 0, we_cnt = 0, done_cnt = 0;
  logic [31:0] addr_log[$];
  logic [7:0]  wd_log[$];
  int          done_log[$];

  always @(negedge clk) begin
    exp_t act, e;
    act = {stall, mem_re, mem_we, done, mem_addr, mem_wdata};
    if (stall) stall_cnt++;
    if (mem_re) re_cnt++;
    if (mem_we) begin
      we_cnt++;
      wd_log.push_back(mem_wdata);
    end
    if (mem_re || mem_we) addr_log.push_back(mem_addr);
    if (done) begin
      done_cnt++;
      done_log.push_back(cyc_rel);
    end
    cyc_rel++;

    if (reset) begin
      q.delete();
      exp_rdata = '0;
      pend_load = 1'b0;
      e = '0;
      e.stall = start;
      check("reset_outputs", 64'(act), 64'(e));
      check("reset_rdata", 64'(rdata_vec), 64'(exp_rdata));
    end else if (q.size() != 0) begin
      e = q.pop_front();
      check("cycle_outputs", 64'(act), 64'(e));
      if (e.we) ref_mem[e.addr] = e.wdata;
      if (e.dn) begin
        if (pend_load) exp_rdata = pend_vec;
        pend_load = 1'b0;
        check("done_rdata", 64'(rdata_vec), 64'(exp_rdata));
      end
    end else begin
      e = '0;
      e.stall = start;
      check("idle_outputs", 64'(act), 64'(e));
      check("idle_rdata", 64'(rdata_vec), 64'(exp_rdata));
      if (start) build(is_write, base_addr, wdata_vec);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    cyc_rel = 0;
    stall_cnt = 0;
    re_cnt = 0;
    we_cnt = 0;
    done_cnt = 0;
    addr_log.delete();
    wd_log.delete();
    done_log.delete();
  endtask

  localparam logic [R*N-1:0] LoadVec = 48'h665544332211;

  initial begin
    logic [31:0] wrap_exp [6];
    wrap_exp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3};

    #12;
    check("reset_state", {stall, mem_re, mem_we, done, mem_addr, mem_wdata, rdata_vec}, 64'h0);
    tick(1);
    reset = 1'b0;

    // Idle: nothing moves without start.
    clr();
    tick(20);
    check("idle_quiet", 64'(stall_cnt + re_cnt + we_cnt + done_cnt), 64'd0);

    // Load from 0x10.
    for (int i = 0; i < R; i++) begin
      bus_mem[32'h10 + 32'(i)] = 8'(17 * (i + 1));
      ref_mem[32'h10 + 32'(i)] = 8'(17 * (i + 1));
    end
    clr();
    start = 1'b1;
    is_write = 1'b0;
    base_addr = 32'h10;
    tick(1);
    start = 1'b0;
    tick(10);
    check("load_stall_cycles", 64'(stall_cnt), 64'd8);
    check("load_re_cycles", 64'(re_cnt), 64'd6);
    check("load_done_cycle", 64'(done_log.size() == 1 ? done_log[0] : -1), 64'd8);
    for (int i = 0; i < R; i++) check("load_addr", 64'(addr_log[i]), 64'(32'h10 + 32'(i)));
    check("load_rdata", 64'(rdata_vec), 64'(LoadVec));

    // Store to 0x20.
    clr();
    start = 1'b1;
    is_write = 1'b1;
    base_addr = 32'h20;
    wdata_vec = 48'hA5A4A3A2A1A0;
    tick(1);
    start = 1'b0;
    tick(10);
    check("store_we_cycles", 64'(we_cnt), 64'd6);
    check("store_done_cycle", 64'(done_log.size() == 1 ? done_log[0] : -1), 64'd7);
    for (int i = 0; i < R; i++) begin
      check("store_addr", 64'(addr_log[i]), 64'(32'h20 + 32'(i)));
      check("store_wdata", 64'(wd_log[i]), 64'(8'hA0 + 8'(i)));
    end
    check("store_keeps_rdata", 64'(rdata_vec), 64'(LoadVec));

    // Address wrap.
    clr();
    start = 1'b1;
    is_write = 1'b0;
    base_addr = 32'hFFFFFFFE;
    tick(1);
    start = 1'b0;
    tick(10);
    check("wrap_count", 64'(addr_log.size()), 64'd6);
    for (int i = 0; i < R; i++) check("wrap_addr", 64'(addr_log[i]), 64'(wrap_exp[i]));

    // Back-to-back store then load with start held high.
    clr();
    start = 1'b1;
    is_write = 1'b1;
    base_addr = 32'h40;
    wdata_vec = 48'h0123456789AB;
    tick(1);
    is_write = 1'b0;
    base_addr = 32'h50;
    tick(8);
    start = 1'b0;
    tick(12);
    check("b2b_done_count", 64'(done_cnt), 64'd2);
    check("b2b_done_store", 64'(done_log.size() > 0 ? done_log[0] : -1), 64'd7);
    check("b2b_done_load", 64'(done_log.size() > 1 ? done_log[1] : -1), 64'd16);
    check("b2b_stall_cycles", 64'(stall_cnt), 64'd15);
    check("b2b_load_addr0", 64'(addr_log.size() > 6 ? addr_log[6] : 32'hDEAD), 64'h50);

    // Reset in the LOAD cycle with idx = 3.
    clr();
    start = 1'b1;
    is_write = 1'b0;
    base_addr = 32'h10;
    tick(1);
    start = 1'b0;
    tick(3);
    check("pre_reset_lane3", {31'd0, mem_re, mem_addr}, {31'd0, 1'b1, 32'h13});
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", {stall, mem_re, mem_we, done, mem_addr, mem_wdata}, 64'h0);
    check("async_reset_rdata", 64'(rdata_vec), 64'h0);
    tick(1);
    reset = 1'b0;
    clr();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    check("post_reset_load_rdata", 64'(rdata_vec), 64'(LoadVec));
    check("post_reset_done_cycle", 64'(done_log.size() == 1 ? done_log[0] : -1), 64'd8);

    // Randomized traffic including occasional asynchronous resets.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = ($urandom_range(0, 2) != 0);
      is_write = 1'($urandom);
      base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                : 32'($urandom_range(0, 63));
      wdata_vec = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 60) == 0) #1 reset = 1'b1;
    end
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Multi-cycle controller that serializes one R-lane vector load or store over the single N-bit data-memory port during the MEM stage. While the transfer runs it freezes the pipeline. On a load it assembles the R lanes into a vector for the MEM/WB segment register. It sits between the EX/MEM segment outputs, the data memory and the MEM/WB segment, and it drives the global stall used by every segment register and the PC.

## Interface
- N, 8, bits per lane (memory word width)
- R, 6, lanes per vector
- A, 32, memory address width
- clk  in  1  clock; FSM and data registers update on the rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  MEM-stage instruction is a vector memory access (MemReadM | MemWriteM)
- is_write  in  1  1 = store, 0 = load; sampled with start
- base_addr  in  A  lane-0 address
- wdata_vec  in  R×N  store data, lane i = element i; sampled with start
- mem_rdata  in  N  memory read data, valid one cycle after mem_re
- mem_addr  out  A  memory address
- mem_wdata  out  N  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- stall  out  1  hold all segment registers and the PC
- rdata_vec  out  R×N  assembled load vector, feeds ReadDataM
- done  out  1  one-cycle pulse; the transfer is complete

## Operation
- States: IDLE, LOAD, DRAIN, STORE, DONE. Lane index idx is a ceil(log2 R)-bit counter.
- **IDLE**
  - stall = start, combinational in the same cycle.
  - On start: latch base_addr, is_write and wdata_vec, and set idx = 0.
  - Next state is STORE if is_write = 1, otherwise LOAD.
  - No memory strobes.
- **LOAD**
  - mem_re = 1 and mem_addr = base + idx.
  - If idx > 0, capture mem_rdata into lane idx−1.
  - idx increments each cycle. After the cycle with idx = R−1, go to DRAIN.
- **DRAIN**
  - Capture mem_rdata into lane R−1.
  - mem_re = 0. Go to DONE.
- **STORE**
  - mem_we = 1, mem_addr = base + idx, mem_wdata = latched lane idx.
  - After the cycle with idx = R−1, go to DONE.
- **DONE**
  - stall = 0 and done = 1 for one cycle. Go to IDLE.
  - start is ignored in DONE. The stalled instruction is still in MEM until the following negedge.
- stall = 1 in LOAD, DRAIN and STORE.
- Address arithmetic is base + idx modulo 2^A. Wrap-around is silent.
- rdata_vec holds its value until the next load overwrites it. Stores never modify rdata_vec.
- mem_addr = 0 and mem_wdata = 0 whenever no strobe is active.
- Inputs other than mem_rdata are ignored outside IDLE. Only the latched copies are used.

## Timing
- Reset values:
  - state = IDLE, idx = 0.
  - rdata_vec = 0, done = 0, mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0.
  - stall follows start (IDLE).
- Load, with start seen in cycle 0:
  - Addresses are issued in cycles 1..R.
  - Lanes are captured in cycles 2..R+1.
  - DONE is cycle R+2. stall is high for cycles 0..R+1 (R+2 cycles).
  - rdata_vec is final from the DONE cycle onward.
- Store, with start seen in cycle 0:
  - Writes occur in cycles 1..R.
  - DONE is cycle R+1. stall is high for R+1 cycles.
- Back-to-back accesses: a start held in the IDLE cycle right after DONE begins a new transfer, with no bubble beyond DONE.
- Reset mid-transfer:
  - Immediate return to IDLE with all outputs at reset values.
  - A partially written store stays in memory. No rollback.
- The segment registers sample on negedge, so stall and rdata_vec are stable for a half cycle before the MEM/WB capture.

## Test plan
- **Load**, R=6, base=0x10, memory[0x10..0x15] = 11,22,33,44,55,66:
  - stall is high for 8 cycles.
  - mem_re is high with addresses 0x10..0x15.
  - rdata_vec = {66,55,44,33,22,11} at done.
- **Store**, base=0x20, wdata_vec lanes 0..5 = A0..A5:
  - mem_we is high for 6 cycles with addresses 0x20..0x25 and data A0..A5.
  - done in cycle 7. rdata_vec is unchanged.
- **Address wrap**, base=0xFFFFFFFE load:
  - Addresses are FFFFFFFE, FFFFFFFF, 0, 1, 2, 3.
- **Back-to-back**: a store immediately followed by a load, with start high continuously:
  - The load's IDLE cycle directly follows the store's DONE cycle.
  - done pulses twice, with no spurious third transfer.
- **Reset mid-transfer**: reset asserted during the LOAD cycle with idx=3:
  - All outputs go to their reset values asynchronously.
  - A fresh load after reset completes correctly.
- **Idle**: start=0 for 20 cycles:
  - stall, mem_we, mem_re and done all stay 0.
